// File: rtl/asip_pkg.sv
// asip_pkg -- shared definitions for the ASIP front end.
//   - control-flow opcode encodings and the opcode field position
//   - loop counter width
//   - fetch FSM state enum
//   - opcode_of(): extracts the opcode field from an instruction word
package asip_pkg;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 28;
  localparam int OP_W       = OP_MSB - OP_LSB + 1;
  localparam int LOOP_CNT_W = 16;

  localparam logic [OP_W-1:0] OP_LDCNT = 4'hC;
  localparam logic [OP_W-1:0] OP_DJNZ  = 4'hD;
  localparam logic [OP_W-1:0] OP_JMP   = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch with in-stage loop/jump/halt handling.
// Control-flow opcodes (LDCNT, DJNZ, JMP, HALT) are consumed here and never
// reach decode; every other word is forwarded as a datapath instruction.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            pulse: begin (or restart) fetching at address 0
//   stall            decode not ready: freeze everything, re-read same word
//   imem_addr        address to synchronous ROM (data returns next cycle)
//   imem_rdata       ROM data for the address presented last cycle
//   instruction      registered instruction to decode
//   instr_valid      instruction is new this cycle
//   pc               address of the word currently on imem_rdata
//   halted           HALT executed, fetch stopped
module fetch_stage
  import asip_pkg::*;
#(
  parameter int IMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic               instr_valid,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted
);

  fetch_state_e            state_q, state_d;
  logic [IMEM_AW-1:0]      pc_q, pc_d;
  logic [LOOP_CNT_W-1:0]   loop_cnt_q, loop_cnt_d;
  logic [31:0]             instruction_q, instruction_d;
  logic                    instr_valid_q, instr_valid_d;
  logic                    halted_q, halted_d;

  logic [OP_W-1:0]         opcode;
  logic [IMEM_AW-1:0]      target;
  logic [IMEM_AW-1:0]      pc_inc;
  logic [LOOP_CNT_W-1:0]   loop_cnt_dec;

  assign opcode       = opcode_of(imem_rdata);
  assign target       = imem_rdata[IMEM_AW-1:0];
  // Natural overflow gives the silent wrap from the top word back to 0.
  assign pc_inc       = pc_q + IMEM_AW'(1);
  assign loop_cnt_dec = loop_cnt_q - LOOP_CNT_W'(1);

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      loop_cnt_q    <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      loop_cnt_q    <= loop_cnt_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state logic. start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (!stall && opcode == OP_HALT) state_d = ST_HALTED;
      ST_HALTED: if (start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    pc_d          = pc_q;
    loop_cnt_d    = loop_cnt_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        instr_valid_d = 1'b0;
        if (start) begin
          pc_d       = '0;
          loop_cnt_d = '0;
          halted_d   = 1'b0;
        end
      end
      ST_RUN: begin
        // Stall freezes everything, regardless of the word on imem_rdata.
        if (!stall) begin
          instr_valid_d = 1'b0;
          case (opcode)
            OP_JMP:   pc_d = target;
            OP_LDCNT: begin
              loop_cnt_d = imem_rdata[LOOP_CNT_W-1:0];
              pc_d       = pc_inc;
            end
            OP_DJNZ: begin
              // An exhausted counter falls through without wrapping.
              if (loop_cnt_q != '0) begin
                loop_cnt_d = loop_cnt_dec;
                pc_d       = (loop_cnt_dec != '0) ? target : pc_inc;
              end else begin
                pc_d = pc_inc;
              end
            end
            OP_HALT:  halted_d = 1'b1;
            default: begin
              instruction_d = imem_rdata;
              instr_valid_d = 1'b1;
              pc_d          = pc_inc;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Outputs. The ROM is given the next pc so that its data lines up with
  // pc_q one cycle later; a held pc makes the ROM re-read the same word.
  always_comb begin
    imem_addr = pc_d;
    if (state_q == ST_IDLE) imem_addr = '0;
  end

  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int AW = 10;

  localparam logic [31:0] W_A    = 32'h1234_5678;
  localparam logic [31:0] W_B    = 32'h2000_0001;
  localparam logic [31:0] W_C    = 32'h3000_0002;
  localparam logic [31:0] W_X    = 32'h3000_00AA;
  localparam logic [31:0] W_Y    = 32'h5000_0022;
  localparam logic [31:0] W_Z    = 32'h4000_0011;
  localparam logic [31:0] I_HALT = 32'hF000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] imem_addr, pc;
  logic [31:0]   imem_rdata, instruction;
  logic          instr_valid, halted;

  logic [31:0]   rom [0:(1<<AW)-1];
  int            n_tests = 0;
  int            n_fail  = 0;

  fetch_stage #(.IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << AW); i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stall = 1'b1;
    tick();
    n_tests++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want %h", instruction, 32'h0); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_tests++; if (pc !== 10'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_tests++; if (imem_addr !== 10'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    rst = 1'b0; start = 1'b0; stall = 1'b0;
  endtask

  // {0:A, 1:B, 2:HALT}, then restart from HALTED.
  task automatic test_straight();
    clear_rom(); rom[0] = W_A; rom[1] = W_B; rom[2] = I_HALT;
    do_reset();
    pulse_start();
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL st_t1_valid: got %b want 0", instr_valid); end
    tick();
    n_tests++; if (instruction !== W_A || instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_a: got %h/%b want %h/1", instruction, instr_valid, W_A); end
    n_tests++; if (pc !== 10'd1) begin n_fail++; $display("FAIL st_pc1: got %h want 1", pc); end
    tick();
    n_tests++; if (instruction !== W_B || instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_b: got %h/%b want %h/1", instruction, instr_valid, W_B); end
    tick();
    n_tests++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL st_halt: got halted=%b valid=%b want 1/0", halted, instr_valid); end
    n_tests++; if (instruction !== W_B || pc !== 10'd2 || imem_addr !== 10'd2) begin n_fail++; $display("FAIL st_halt_hold: got %h pc=%h addr=%h want %h pc=2 addr=2", instruction, pc, imem_addr, W_B); end
    tick(); tick();
    n_tests++; if (instr_valid !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL st_halt_stay: got valid=%b halted=%b want 0/1", instr_valid, halted); end
    pulse_start();
    n_tests++; if (halted !== 1'b0 || pc !== 10'd0) begin n_fail++; $display("FAIL st_restart: got halted=%b pc=%h want 0/0", halted, pc); end
    tick();
    n_tests++; if (instruction !== W_A || instr_valid !== 1'b1) begin n_fail++; $display("FAIL st_restart_a: got %h/%b want %h/1", instruction, instr_valid, W_A); end
  endtask

  // {0:LDCNT 3, 1:X, 2:DJNZ 1, 3:HALT}
  task automatic test_loop();
    logic [7:1] vpat;
    int x_cnt, halt_step;
    clear_rom(); rom[0] = 32'hC000_0003; rom[1] = W_X; rom[2] = 32'hD000_0001; rom[3] = I_HALT;
    do_reset();
    pulse_start();
    vpat = '0; x_cnt = 0; halt_step = -1;
    for (int s = 1; s <= 40; s++) begin
      tick();
      if (halted) begin halt_step = s; break; end
      if (s <= 7) vpat[s] = instr_valid;
      if (instr_valid && instruction === W_X) x_cnt++;
    end
    n_tests++; if (halt_step != 8) begin n_fail++; $display("FAIL loop_halt_step: got %0d want 8", halt_step); end
    n_tests++; if (x_cnt != 3) begin n_fail++; $display("FAIL loop_x_count: got %0d want 3", x_cnt); end
    n_tests++; if (vpat !== 7'b0101010) begin n_fail++; $display("FAIL loop_valid_pattern: got %b want 0101010", vpat); end
  endtask

  // {0:Y, 1:JMP 0x3FF, 0x3FF:Z}: wrap to 0 with no extra bubble; start in RUN ignored.
  task automatic test_wrap();
    clear_rom(); rom[0] = W_Y; rom[1] = 32'hE000_03FF; rom[1023] = W_Z;
    do_reset();
    pulse_start();
    tick();
    n_tests++; if (instruction !== W_Y || pc !== 10'd1) begin n_fail++; $display("FAIL wr_y: got %h pc=%h want %h pc=1", instruction, pc, W_Y); end
    tick();
    n_tests++; if (instr_valid !== 1'b0 || pc !== 10'h3FF) begin n_fail++; $display("FAIL wr_jmp: got valid=%b pc=%h want 0/3ff", instr_valid, pc); end
    tick();
    n_tests++; if (instruction !== W_Z || instr_valid !== 1'b1 || pc !== 10'h0) begin n_fail++; $display("FAIL wr_z: got %h/%b pc=%h want %h/1 pc=0", instruction, instr_valid, pc, W_Z); end
    tick();
    n_tests++; if (instruction !== W_Y || instr_valid !== 1'b1 || pc !== 10'd1) begin n_fail++; $display("FAIL wr_y2: got %h/%b pc=%h want %h/1 pc=1", instruction, instr_valid, pc, W_Y); end
    pulse_start();
    n_tests++; if (pc !== 10'h3FF || instr_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL wr_start_ignored: got pc=%h valid=%b halted=%b want 3ff/0/0", pc, instr_valid, halted); end
  endtask

  // Stall 3 cycles while B is on imem_rdata.
  task automatic test_stall();
    clear_rom(); rom[0] = W_A; rom[1] = W_B; rom[2] = W_C; rom[3] = I_HALT;
    do_reset();
    pulse_start();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (instruction !== W_A || instr_valid !== 1'b1 || pc !== 10'd1 || imem_addr !== 10'd1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h/%b pc=%h addr=%h want %h/1 pc=1 addr=1", i, instruction, instr_valid, pc, imem_addr, W_A);
      end
    end
    stall = 1'b0;
    tick();
    n_tests++; if (instruction !== W_B || instr_valid !== 1'b1 || pc !== 10'd2) begin n_fail++; $display("FAIL stall_b: got %h/%b pc=%h want %h/1 pc=2", instruction, instr_valid, pc, W_B); end
    tick();
    n_tests++; if (instruction !== W_C || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_c: got %h/%b want %h/1", instruction, instr_valid, W_C); end
    tick();
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stall_halt: got %b want 1", halted); end
  endtask

  // rst mid-loop (loop_cnt=2) outranks start and stall.
  task automatic test_rst_mid_loop();
    clear_rom(); rom[0] = 32'hC000_0003; rom[1] = W_X; rom[2] = 32'hD000_0001; rom[3] = I_HALT;
    do_reset();
    pulse_start();
    tick(); tick(); tick();
    rst = 1'b1; start = 1'b1; stall = 1'b1;
    tick();
    n_tests++; if (instruction !== 32'h0 || instr_valid !== 1'b0 || pc !== 10'h0 || halted !== 1'b0 || imem_addr !== 10'h0) begin
      n_fail++; $display("FAIL mid_rst: got %h/%b pc=%h halted=%b addr=%h want 0/0 pc=0 halted=0 addr=0", instruction, instr_valid, pc, halted, imem_addr);
    end
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    tick();
    n_tests++; if (instr_valid !== 1'b0 || imem_addr !== 10'h0) begin n_fail++; $display("FAIL mid_idle: got valid=%b addr=%h want 0/0", instr_valid, imem_addr); end
    pulse_start();
    tick();
    n_tests++; if (pc !== 10'd1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ldcnt: got pc=%h valid=%b want 1/0", pc, instr_valid); end
    tick();
    n_tests++; if (instruction !== W_X || instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_refetch_x: got %h/%b want %h/1", instruction, instr_valid, W_X); end
  endtask

  // Two DJNZ with counter 0: both fall through, counter never wraps.
  task automatic test_djnz_zero();
    clear_rom(); rom[0] = W_A; rom[1] = 32'hD000_0000; rom[2] = 32'hD000_0000; rom[3] = W_B; rom[4] = I_HALT;
    do_reset();
    pulse_start();
    tick();
    tick();
    n_tests++; if (pc !== 10'd2 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL dz_first: got pc=%h valid=%b want 2/0", pc, instr_valid); end
    tick();
    n_tests++; if (pc !== 10'd3 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL dz_second: got pc=%h valid=%b want 3/0", pc, instr_valid); end
    tick();
    n_tests++; if (instruction !== W_B || instr_valid !== 1'b1 || pc !== 10'd4) begin n_fail++; $display("FAIL dz_b: got %h/%b pc=%h want %h/1 pc=4", instruction, instr_valid, pc, W_B); end
    tick();
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL dz_halt: got %b want 1", halted); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_straight();
    test_loop();
    test_wrap();
    test_stall();
    test_rst_mid_loop();
    test_djnz_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
